// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel sync, optional debounce, edge detect,
// pulse/sticky/saturating-counter outputs. Optional filter: MULTI_EDGE_DEBOUNCE_EN.
//
// Ports:
//   sys_clk, sys_rst_n  - clock, synchronous active-low reset
//   sig_in[CH]          - raw (possibly asynchronous) input lines
//   mode[2*CH]          - per channel {fall_en, rise_en}
//   sticky_clr[CH]      - per-channel sticky clear strobe
//   cnt_clr             - clear all event counters
//   level_out[CH]       - accepted (synchronised, filtered) level
//   edge_pulse[CH]      - one-cycle pulse per qualified edge
//   rise_pulse[CH]      - one-cycle pulse per accepted rise (mode-independent)
//   fall_pulse[CH]      - one-cycle pulse per accepted fall (mode-independent)
//   event_sticky[CH]    - latched event flag
//   event_count[CH*CNT_W] - saturating qualified-edge counters
//   any_event           - OR of qualified edges, registered with edge_pulse
module multi_edge_detector #(
    parameter int CH              = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [CH-1:0]       sig_in,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       sticky_clr,
    input  logic                cnt_clr,
    output logic [CH-1:0]       level_out,
    output logic [CH-1:0]       edge_pulse,
    output logic [CH-1:0]       rise_pulse,
    output logic [CH-1:0]       fall_pulse,
    output logic [CH-1:0]       event_sticky,
    output logic [CH*CNT_W-1:0] event_count,
    output logic                any_event
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Synchroniser chain; the last stage is the synchronised sample.
    logic [CH-1:0] sync_q [SYNC_STAGES];
    logic [CH-1:0] s;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Accepted level and its one-cycle delayed copy.
    logic [CH-1:0] lvl_q, lvl_d;
    logic [CH-1:0] dly_q;

`ifdef MULTI_EDGE_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [DBW-1:0] db_q [CH];
    logic [DBW-1:0] db_d [CH];

    // A level change is accepted only after the new value has been seen
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < CH; i++) begin
            db_d[i] = '0;
            if (s[i] != lvl_q[i]) begin
                if (db_q[i] == DB_LAST) begin
                    lvl_d[i] = s[i];
                end else begin
                    db_d[i] = db_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < CH; i++) db_q[i] <= '0;
        end else begin
            for (int i = 0; i < CH; i++) db_q[i] <= db_d[i];
        end
    end
`else
    assign lvl_d = s;
`endif

    // Edge detection on the accepted level.
    logic [CH-1:0] rise, fall, qual;

    assign rise = lvl_q & ~dly_q;
    assign fall = ~lvl_q & dly_q;

    always_comb begin
        qual = '0;
        for (int i = 0; i < CH; i++) begin
            qual[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
        end
    end

    // Sticky flag: a new event in the same cycle beats the clear.
    logic [CH-1:0] sticky_q, sticky_d;

    assign sticky_d = qual | (sticky_q & ~sticky_clr);

    // Saturating counters; a global clear coinciding with an event loads 1.
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = CNT_W'(qual[i]);
            end else if (qual[i] && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    logic [CH-1:0] edge_q, rise_q, fall_q;
    logic          any_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            lvl_q    <= '0;
            dly_q    <= '0;
            edge_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
            sticky_q <= '0;
            for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
        end else begin
            lvl_q    <= lvl_d;
            dly_q    <= lvl_q;
            edge_q   <= qual;
            rise_q   <= rise;
            fall_q   <= fall;
            any_q    <= |qual;
            sticky_q <= sticky_d;
            for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign level_out    = lvl_q;
    assign edge_pulse   = edge_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign any_event    = any_q;
    assign event_sticky = sticky_q;

    for (genvar g = 0; g < CH; g++) begin : g_cnt
        assign event_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule
